// File: rtl/cv32e40p_fault_manager.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_fault_manager
// Brief    : Collects voter fault flags, sequences flush/replay recovery and
//            escalates to a halt request once recovery keeps failing.
// Revision : 1.0 - initial release
// ============================================================================

module cv32e40p_fault_manager #(
    parameter int NUM_UNITS         = 4,
    parameter int CNT_WIDTH         = 8,
    parameter int PERSIST_THRESHOLD = 3,
    parameter int RECOVERY_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_UNITS-1:0] fault_i,
    input  logic                 clear_i,
    input  logic                 ack_i,
    output logic [NUM_UNITS-1:0] fault_status_o,
    output logic [CNT_WIDTH-1:0] fault_count_o,
    output logic                 recovery_req_o,
    output logic                 halt_req_o,
    output logic                 irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_RECOVER_REQ  = 2'd1,
        ST_RECOVER_WAIT = 2'd2,
        ST_HALT         = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [3:0]           C_RETRY_LAST = 4'(PERSIST_THRESHOLD - 1);
    localparam logic [7:0]           C_WIN_LAST   = 8'(RECOVERY_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_retry;
    logic [3:0]           w_retry_next;
    logic [7:0]           r_win;
    logic [7:0]           w_win_next;
    logic                 r_refault;
    logic                 w_refault_next;
    logic                 w_refault_seen;
    logic                 w_irq_next;
    logic                 w_any_fault;
    logic [NUM_UNITS-1:0] r_status;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_recovery_req;
    logic                 r_halt_req;
    logic                 r_irq;

    assign w_any_fault = |fault_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_retry   <= 4'd0;
            r_win     <= 8'd0;
            r_refault <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_retry   <= w_retry_next;
            r_win     <= w_win_next;
            r_refault <= w_refault_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_retry_next   = r_retry;
        w_win_next     = r_win;
        w_refault_next = r_refault;
        w_refault_seen = r_refault | w_any_fault;
        w_irq_next     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_fault) begin
                    w_state_next = ST_RECOVER_REQ;
                    w_retry_next = 4'd0;
                    w_irq_next   = 1'b1;
                end
            end
            ST_RECOVER_REQ: begin
                if (ack_i) begin
                    w_state_next   = ST_RECOVER_WAIT;
                    w_win_next     = 8'd0;
                    w_refault_next = 1'b0;
                end
            end
            ST_RECOVER_WAIT: begin
                if (r_win == C_WIN_LAST) begin
                    w_win_next     = 8'd0;
                    w_refault_next = 1'b0;
                    if (!w_refault_seen) begin
                        w_state_next = ST_IDLE;
                        w_retry_next = 4'd0;
                    end else if (r_retry == C_RETRY_LAST) begin
                        w_state_next = ST_HALT;
                        w_irq_next   = 1'b1;
                    end else begin
                        w_state_next = ST_RECOVER_REQ;
                        w_retry_next = r_retry + 4'd1;
                    end
                end else begin
                    w_win_next     = r_win + 8'd1;
                    w_refault_next = w_refault_seen;
                end
            end
            ST_HALT: begin
                if (clear_i) begin
                    w_state_next = ST_IDLE;
                    w_retry_next = 4'd0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A clear coinciding with a fault reloads from that fault so it is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_status <= fault_i;
            r_count  <= w_any_fault ? C_CNT_ONE : '0;
        end else begin
            r_status <= r_status | fault_i;
            if (w_any_fault && (r_count != C_CNT_MAX)) begin
                r_count <= r_count + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_recovery_req <= 1'b0;
            r_halt_req     <= 1'b0;
            r_irq          <= 1'b0;
        end else begin
            r_recovery_req <= (w_state_next == ST_RECOVER_REQ);
            r_halt_req     <= (w_state_next == ST_HALT);
            r_irq          <= w_irq_next;
        end
    end

    assign fault_status_o = r_status;
    assign fault_count_o  = r_count;
    assign recovery_req_o = r_recovery_req;
    assign halt_req_o     = r_halt_req;
    assign irq_o          = r_irq;

endmodule

`default_nettype wire

// File: doc/cv32e40p_fault_manager.md
CV32E40P_FAULT_MANAGER -- requirements
Module: cv32e40p_fault_manager

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of hardened units whose voter fault flags are collected.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the saturating fault-event counter.
REQ-003 SHALL have parameter PERSIST_THRESHOLD, default 3 (legal 1..15), consecutive failed recoveries that declare a permanent fault.
REQ-004 SHALL have parameter RECOVERY_CYCLES, default 2 (legal 1..255), length of the post-acknowledge observation window.
REQ-005 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port fault_i  input  NUM_UNITS  per-unit voter mismatch flags, bit k = unit k, sampled every cycle.
REQ-008 SHALL have port clear_i  input  1  software clear of status/counter; exit from HALT.
REQ-009 SHALL have port ack_i  input  1  controller acknowledge of recovery request.
REQ-010 SHALL have port fault_status_o  output  NUM_UNITS  sticky per-unit fault record.
REQ-011 SHALL have port fault_count_o  output  CNT_WIDTH  saturating count of fault cycles.
REQ-012 SHALL have port recovery_req_o  output  1  flush/replay request to controller.
REQ-013 SHALL have port halt_req_o  output  1  permanent-fault halt request.
REQ-014 SHALL have port irq_o  output  1  single-cycle fault interrupt pulse.

Function
REQ-015 SHALL implement states IDLE, RECOVER_REQ, RECOVER_WAIT, HALT; all outputs registered, 1-cycle latency from inputs.
REQ-016 SHALL set fault_status_o[k] on the edge after fault_i[k]=1; bits stay set until clear_i.
REQ-017 SHALL increment fault_count_o by exactly 1 per cycle with any fault_i bit set (not popcount), saturating at all-ones.
REQ-018 SHALL, on clear_i with fault_i=0, zero fault_status_o and fault_count_o next edge; with fault_i!=0 same cycle, load fault_status_o=fault_i and fault_count_o=1 (no fault lost).
REQ-019 SHALL, in IDLE with any fault_i bit set, go to RECOVER_REQ with retry counter 0 and pulse irq_o for one cycle.
REQ-020 SHALL hold recovery_req_o=1 exactly while in RECOVER_REQ.
REQ-021 SHALL, in RECOVER_REQ with ack_i=1, go to RECOVER_WAIT next edge (recovery_req_o drops same edge); ack_i in any other state is ignored.
REQ-022 SHALL remain in RECOVER_WAIT exactly RECOVERY_CYCLES cycles, recording a refault flag if any fault_i bit is set in any of those cycles.
REQ-023 SHALL, at end of RECOVER_WAIT without refault, go to IDLE and zero the retry counter.
REQ-024 SHALL, at end of RECOVER_WAIT with refault, go to HALT if retry counter equals PERSIST_THRESHOLD-1, else increment it and return to RECOVER_REQ (no irq_o pulse).
REQ-025 SHALL, on entry to HALT, pulse irq_o one cycle and hold halt_req_o=1 while in HALT.
REQ-026 SHALL leave HALT to IDLE only on clear_i, zeroing the retry counter; clear_i in other states does not affect the state machine.
REQ-027 SHALL, for faults in RECOVER_REQ or HALT, update status/counter only, with no state change.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-recovery, immediately enter IDLE and drive all outputs, retry counter, refault flag and window counter to 0.

Verification
REQ-029 Single fault: fault_i=4'b0010 for 1 cycle -> next cycle fault_status_o=4'b0010, fault_count_o=1, recovery_req_o=1, irq_o=1 for one cycle; ack_i -> 2 cycles RECOVER_WAIT -> IDLE.
REQ-030 Permanent fault: fault_i=4'b0001 held high, ack_i=1 always -> three failed windows, halt_req_o=1, irq_o second pulse at HALT entry; clear_i=1 -> IDLE next cycle, status/count reloaded to 4'b0001/1 if fault still present.
REQ-031 Saturation: CNT_WIDTH=8, fault_i nonzero 300 cycles -> fault_count_o stops at 255.
REQ-032 Clear/fault collision: status=4'b1111, count=9; clear_i with fault_i=4'b0100 -> status=4'b0100, count=1.
REQ-033 Ack stall: fault then ack_i=0 for 10 cycles -> recovery_req_o stays 1, state stays RECOVER_REQ; further faults only increment count.
REQ-034 Reset mid-WAIT: rst_n low during RECOVER_WAIT -> all outputs 0 asynchronously, IDLE after release.
